rgb_grayscaler: RTL and testbench
=================================

Name: rgb_grayscaler

Overview:
- Consumer end of the RGB pixel memory read interface. Reads R,G,B bytes for each pixel from the pixel memory and emits one 8-bit gray byte per pixel to the downstream stage.
- Throttles the memory with the `pause` handshake whenever it cannot accept more bytes.
- Started by the controller once per frame of N*M pixels; reports completion with a `gs_done` pulse.

Parameters:
- N, 2, image height in pixels
- M, 2, image width in pixels (frame = N*M pixels = 3*N*M input bytes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gs_enable  in  1  controller start; sampled only in IDLE
- rgb_in  in  8  pixel byte from memory; order R,G,B per pixel
- rgb_valid  in  1  rgb_in holds a byte this cycle; memory advances its address every cycle this is high
- pause  out  1  asks the memory to stall its read
- gray_out  out  8  gray byte to downstream
- gray_valid  out  1  gray_out valid
- gray_ready  in  1  downstream accepts gray_out this cycle
- gs_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state=IDLE; pause=0, gray_valid=0, gray_out=8'h00, gs_done=0. Pixel counter, byte registers and product registers are all cleared.
- Reset mid-frame aborts the frame with no gs_done. The upstream memory is resynchronised by the controller.
- States: IDLE, GET_R, GET_G, GET_B, CALC, OUT, DONE.
- IDLE: if gs_enable, go to GET_R and clear the pixel counter. Otherwise stay in IDLE.
- GET_R / GET_G / GET_B: on rgb_valid, capture the byte into r/g/b and advance to the next state. With no valid byte, hold.
- From GET_B with rgb_valid, go to CALC.
- CALC (1 cycle): compute the sum into a 16-bit register, then go to OUT.
- OUT: gray_valid=1 and gray_out=sum[15:8], held stable until gray_ready.
- On gray_ready in OUT:
  - If pixel counter == N*M-1, go to DONE.
  - Otherwise increment the counter and go to GET_R.
- DONE: gs_done=1 for exactly one cycle, then go to IDLE.
- pause (combinational) = (GET_B && rgb_valid) || CALC || (OUT && !gray_ready).
  - The B byte presented in the cycle pause rises is still accepted, because memory consumes that address.
  - No byte ever arrives while in CALC or OUT. If rgb_valid is high there, the byte is dropped (a protocol error; the bench flags it).
- Latency: B byte captured at cycle t; gray_valid first high at t+2. Minimum cost is 5 cycles per pixel.
- Arithmetic (weighted): sum = 77*R + 150*G + 29*B.
  - Maximum is 255*256 = 65280, so the sum fits 16 bits unsigned with no saturation.
  - gray = sum>>8.
- gs_enable high outside IDLE is ignored.
- gray_ready high while gray_valid=0 has no effect.
- Counter wraps to 0 on entry to IDLE.

Optional Feature:
- Macro: GS_WEIGHTED_LUMA_EN.
- Defined: BT.601 weighting as above.
- Undefined: cheap average, gray = (R + 2*G + B)>>2.
  - 10-bit intermediate, maximum 1020, so gray maximum is 255.
  - CALC state and latency are unchanged.

Decomposition:
- Shared package holds:
  - state encoding constants for IDLE..DONE (3-bit);
  - luma weights GS_WR=77, GS_WG=150, GS_WB=29;
  - shift GS_SHIFT=8.
- One sub-module, gray_luma_calc: purely combinational (r,g,b) -> 8-bit gray. It contains the GS_WEIGHTED_LUMA_EN switch. The top FSM registers its output in CALC.

Test Plan:
- Weighted, N=M=2, pixels (255,0,0),(0,255,0),(0,0,255),(255,255,255), gray_ready tied 1 -> gray_out 76,149,28,255 in order; gs_done pulses once, 1 cycle after the 4th handshake.
- Macro undefined, pixels (255,0,0),(0,255,0),(100,100,100),(255,255,255) -> gray_out 63,127,100,255.
- Backpressure: gray_ready low for 5 cycles in OUT -> pause high throughout, gray_out/gray_valid stable; when ready rises, 1 handshake occurs and pause drops the same cycle.
- pause timing: B byte with rgb_valid -> pause high that cycle; next pixel's R byte is not lost or duplicated over 3 frames against a memory model.
- rst asserted in GET_G mid-frame -> next cycle all outputs 0, state IDLE, no gs_done; a new gs_enable starts a fresh frame and produces correct grays.
- rgb_valid gapped (1 valid every 3 cycles) -> identical gray sequence to the ungapped run; gs_enable pulsed during OUT is ignored.

Source files
------------

// File: rtl/rgb_grayscaler_pkg.sv
// Shared state encoding, luma weights and multiply helper for the RGB-to-gray block.
// GS_WEIGHTED_LUMA_EN selects the BT.601 weighting in gray_luma_calc.
package rgb_grayscaler_pkg;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_GET_R = 3'd1,
    GS_GET_G = 3'd2,
    GS_GET_B = 3'd3,
    GS_CALC  = 3'd4,
    GS_OUT   = 3'd5,
    GS_DONE  = 3'd6
  } gs_state_t;

  localparam logic [7:0] GS_WR    = 8'd77;
  localparam logic [7:0] GS_WG    = 8'd150;
  localparam logic [7:0] GS_WB    = 8'd29;
  localparam int         GS_SHIFT = 8;

  function automatic logic [15:0] gs_mul(input logic [7:0] w, input logic [7:0] x);
    return 16'(w) * 16'(x);
  endfunction

endpackage

// File: rtl/gray_luma_calc.sv
// Combinational (r,g,b) -> gray, zero latency, no flow control.
// GS_WEIGHTED_LUMA_EN: 77R+150G+29B >> 8; otherwise (R+2G+B) >> 2.
module gray_luma_calc
  import rgb_grayscaler_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] gray
);

`ifdef GS_WEIGHTED_LUMA_EN
  // Weights sum to 256, so the peak is 255*256 and the sum never overflows 16 bits.
  logic [15:0] sum;
  logic [15:0] sum_sh;

  assign sum    = gs_mul(GS_WR, r) + gs_mul(GS_WG, g) + gs_mul(GS_WB, b);
  assign sum_sh = sum >> GS_SHIFT;
  assign gray   = sum_sh[7:0];
`else
  logic [9:0] sum;

  assign sum  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
  assign gray = sum[9:2];
`endif

endmodule

// File: rtl/rgb_grayscaler.sv
// Reads R,G,B bytes per pixel, emits one gray byte per pixel; B-to-gray_valid is 2 cycles, >=5 cycles/pixel.
// pause stalls memory from the accepted B byte until the gray byte is taken. Luma mode: GS_WEIGHTED_LUMA_EN.
module rgb_grayscaler
  import rgb_grayscaler_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gs_enable,
  input  logic [7:0] rgb_in,
  input  logic       rgb_valid,
  output logic       pause,
  output logic [7:0] gray_out,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       gs_done
);

  localparam int unsigned NPIX = N * M;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  gs_state_t     state, state_nxt;
  logic [CW-1:0] pix_cnt;
  logic [7:0]    r_q, g_q, b_q;
  logic [7:0]    gray_q;
  logic [7:0]    gray_calc;
  logic          last_pix;

  assign last_pix = (pix_cnt == LAST_PIX);

  gray_luma_calc u_luma (
    .r    (r_q),
    .g    (g_q),
    .b    (b_q),
    .gray (gray_calc)
  );

  always_comb begin
    state_nxt  = state;
    pause      = 1'b0;
    gray_valid = 1'b0;
    gs_done    = 1'b0;
    case (state)
      GS_IDLE:  if (gs_enable) state_nxt = GS_GET_R;
      GS_GET_R: if (rgb_valid) state_nxt = GS_GET_G;
      GS_GET_G: if (rgb_valid) state_nxt = GS_GET_B;
      GS_GET_B: begin
        // Memory consumes the address presented with this B byte, so stall from here on.
        if (rgb_valid) begin
          state_nxt = GS_CALC;
          pause     = 1'b1;
        end
      end
      GS_CALC: begin
        pause     = 1'b1;
        state_nxt = GS_OUT;
      end
      GS_OUT: begin
        gray_valid = 1'b1;
        if (gray_ready) state_nxt = last_pix ? GS_DONE : GS_GET_R;
        else            pause     = 1'b1;
      end
      GS_DONE: begin
        gs_done   = 1'b1;
        state_nxt = GS_IDLE;
      end
      default: state_nxt = GS_IDLE;
    endcase
  end

  assign gray_out = gray_valid ? gray_q : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= GS_IDLE;
      pix_cnt <= '0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
      gray_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        GS_IDLE:  if (gs_enable) pix_cnt <= '0;
        GS_GET_R: if (rgb_valid) r_q <= rgb_in;
        GS_GET_G: if (rgb_valid) g_q <= rgb_in;
        GS_GET_B: if (rgb_valid) b_q <= rgb_in;
        GS_CALC:  gray_q <= gray_calc;
        GS_OUT:   if (gray_ready && !last_pix) pix_cnt <= pix_cnt + 1'b1;
        GS_DONE:  pix_cnt <= '0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_grayscaler.sv
// Self-checking bench: memory model with pause throttling, arithmetic luma model and scoreboard.
module tb_rgb_grayscaler;

  localparam int N    = 2;
  localparam int M    = 2;
  localparam int NPIX = N * M;

  logic       clk = 1'b0;
  logic       rst;
  logic       gs_enable;
  logic [7:0] rgb_in;
  logic       rgb_valid;
  logic       pause;
  logic [7:0] gray_out;
  logic       gray_valid;
  logic       gray_ready;
  logic       gs_done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] fb[$];
  int         got_q[$];
  int         ref_q[$];
  int         lit[4];

  always #5 clk = ~clk;

  rgb_grayscaler #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .gs_enable  (gs_enable),
    .rgb_in     (rgb_in),
    .rgb_valid  (rgb_valid),
    .pause      (pause),
    .gray_out   (gray_out),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .gs_done    (gs_done)
  );

  function automatic int model_gray(input int r, input int g, input int b);
`ifdef GS_WEIGHTED_LUMA_EN
    return (77 * r + 150 * g + 29 * b) / 256;
`else
    return (r + 2 * g + b) / 4;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_px(input int r, input int g, input int b);
    fb.push_back(8'(r));
    fb.push_back(8'(g));
    fb.push_back(8'(b));
  endtask

  task automatic rand_frame();
    fb.delete();
    for (int p = 0; p < NPIX; p++)
      for (int k = 0; k < 3; k++)
        case ($urandom_range(0, 5))
          0:       fb.push_back(8'd0);
          1:       fb.push_back(8'd255);
          default: fb.push_back(8'($urandom));
        endcase
  endtask

  // gap: offer a byte only every gap cycles; rmode: 0 ready=1, 1 random, 2 five-cycle stall on pixel 0;
  // abort_at: pulse rst once this many bytes have been consumed; poke: pulse gs_enable in the first OUT.
  task automatic run_frame(input int gap, input int rmode, input int abort_at, input bit poke);
    int exp_q[$];
    int nb, bi, hs, cyc, t_b, last_hs, done_cnt, rst_cyc;
    bit prev_stall, prev_vld, aborted, poked, ended;
    logic [7:0] prev_gray, nr;
    bit nv, ne, ngr, nrst;
    nb = fb.size();
    for (int p = 0; p < nb / 3; p++)
      exp_q.push_back(model_gray(int'(fb[3*p]), int'(fb[3*p+1]), int'(fb[3*p+2])));
    got_q.delete();
    bi = 0; hs = 0; cyc = 0; t_b = -100; last_hs = -100; done_cnt = 0; rst_cyc = -100;
    prev_stall = 0; prev_vld = 0; aborted = 0; poked = 0; ended = 0; prev_gray = 8'h00;
    nv = 0; nr = 8'h00; ne = 1; nrst = 0;
    ngr = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 600 && !ended; c++) begin
      @(posedge clk); #1;
      gs_enable  = ne;
      rgb_valid  = nv;
      rgb_in     = nr;
      gray_ready = ngr;
      rst        = nrst;
      @(negedge clk);
      cyc++;
      if (rgb_valid) begin
        if (bi % 3 == 2) begin
          check("pause_with_b", int'(pause), 1);
          t_b = cyc;
        end else begin
          check("pause_with_rg", int'(pause), 0);
        end
        bi++;
      end
      if (rst) rst_cyc = cyc;
      if (cyc == rst_cyc + 1) begin
        check("abort_pause", int'(pause), 0);
        check("abort_gray_valid", int'(gray_valid), 0);
        check("abort_gray_out", int'(gray_out), 0);
        check("abort_gs_done", int'(gs_done), 0);
      end
      if (gray_valid) begin
        if (!prev_vld && t_b >= 0) check("latency_b_to_valid", cyc - t_b, 2);
        if (prev_stall) check("gray_held_stable", int'(gray_out), int'(prev_gray));
        if (gray_ready) begin
          check("pause_drops_on_handshake", int'(pause), 0);
          if (hs < exp_q.size()) check("gray_value", int'(gray_out), exp_q[hs]);
          else                   check("extra_gray_beat", hs, exp_q.size() - 1);
          got_q.push_back(int'(gray_out));
          hs++;
          last_hs = cyc;
        end else begin
          check("pause_while_stalled", int'(pause), 1);
        end
        prev_stall = !gray_ready;
        prev_gray  = gray_out;
      end else begin
        if (prev_stall) check("gray_valid_held", int'(gray_valid), 1);
        prev_stall = 0;
      end
      prev_vld = gray_valid;
      if (gs_done) begin
        done_cnt++;
        check("gs_done_timing", cyc - last_hs, 1);
      end
      if (!aborted && hs == NPIX && cyc == last_hs + 2) begin
        check("gs_done_count", done_cnt, 1);
        check("bytes_consumed", bi, nb);
        ended = 1;
      end
      if (aborted && cyc == rst_cyc + 4) begin
        check("abort_no_gs_done", done_cnt, 0);
        ended = 1;
      end
      // next-cycle stimulus
      nrst = 0;
      if (abort_at >= 0 && !aborted && bi == abort_at) begin
        nrst    = 1;
        aborted = 1;
      end
      ne = 0;
      if (poke && !poked && t_b > 0 && cyc == t_b + 1) begin
        ne    = 1;
        poked = 1;
      end
      nv = !aborted && (bi < nb) && !pause && (cyc % gap == 0);
      nr = nv ? fb[bi] : 8'($urandom);
      case (rmode)
        1:       ngr = 1'($urandom_range(0, 1));
        2:       ngr = !(hs == 0 && t_b > 0 && cyc + 1 >= t_b + 2 && cyc + 1 <= t_b + 6);
        default: ngr = 1'b1;
      endcase
    end
    check("frame_finished_in_budget", int'(ended), 1);
    @(posedge clk); #1;
    gs_enable = 0; rgb_valid = 0; gray_ready = 0; rst = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1; gs_enable = 0; rgb_in = 8'h00; rgb_valid = 0; gray_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pause", int'(pause), 0);
    check("reset_gray_valid", int'(gray_valid), 0);
    check("reset_gray_out", int'(gray_out), 0);
    check("reset_gs_done", int'(gs_done), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);

    fb.delete();
`ifdef GS_WEIGHTED_LUMA_EN
    push_px(255, 0, 0); push_px(0, 255, 0); push_px(0, 0, 255); push_px(255, 255, 255);
    lit[0] = 76; lit[1] = 149; lit[2] = 28; lit[3] = 255;
`else
    push_px(255, 0, 0); push_px(0, 255, 0); push_px(100, 100, 100); push_px(255, 255, 255);
    lit[0] = 63; lit[1] = 127; lit[2] = 100; lit[3] = 255;
`endif
    run_frame(1, 0, -1, 0);
    for (int i = 0; i < 4; i++)
      check("literal_gray", (i < got_q.size()) ? got_q[i] : -1, lit[i]);

    rand_frame();
    run_frame(1, 2, -1, 0);

    repeat (3) begin
      rand_frame();
      run_frame(1, 1, -1, 0);
    end

    rand_frame();
    run_frame(1, 0, 4, 0);
    rand_frame();
    run_frame(1, 0, -1, 0);

    rand_frame();
    run_frame(1, 0, -1, 0);
    ref_q = got_q;
    run_frame(3, 1, -1, 1);
    check("gapped_count", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++)
      check("gapped_vs_ungapped", (i < got_q.size()) ? got_q[i] : -1, ref_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
